// File: rtl/axis_frame_len_arb_pkg.sv
// Shared types and helpers for the frame-length arbiter.
//  arb_state_e : arbiter FSM states
//  popcount32  : number of set bits in a 32-bit word
//  rr_next     : next round-robin index, wrapping modulo the port count
package axis_frame_len_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  function automatic int unsigned rr_next(input int unsigned p, input int unsigned ports);
    return (p + 1 >= ports) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/axis_frame_len_arb_len.sv
// Frame length counter for one passively monitored AXI-stream.
// Counts beats (or tkeep bytes) and publishes the total one cycle after tlast.
//  clk, rst         : clock, synchronous active-high reset
//  tkeep            : byte enables of the monitored beat
//  tvalid/tready    : handshake of the monitored beat
//  tlast            : frame end marker
//  frame_len        : length of the last completed frame
//  frame_len_valid  : 1-cycle pulse when frame_len is new
module axis_frame_len_arb_len
  import axis_frame_len_arb_pkg::*;
#(
  parameter bit          KEEP_ENABLE = 1'b0,
  parameter int unsigned KEEP_WIDTH  = 1,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEEP_WIDTH-1:0] tkeep,
  input  logic                  tvalid,
  input  logic                  tready,
  input  logic                  tlast,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid
);

  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] beat_inc_c;
  logic [LEN_WIDTH-1:0] count_inc_c;

  // Per-beat increment: byte count from tkeep, or one per beat
  always_comb begin
    beat_inc_c  = KEEP_ENABLE ? LEN_WIDTH'(popcount32(32'(tkeep))) : LEN_WIDTH'(1);
    count_inc_c = count + beat_inc_c;
  end

  // Accumulate and publish on tlast
  always_ff @(posedge clk) begin
    if (rst) begin
      count           <= '0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
    end else begin
      frame_len_valid <= 1'b0;
      if (tvalid && tready) begin
        if (tlast) begin
          frame_len       <= count_inc_c;
          frame_len_valid <= 1'b1;
          count           <= '0;
        end else begin
          count <= count_inc_c;
        end
      end
    end
  end

endmodule

// File: rtl/axis_frame_len_arb.sv
// Shares one frame length counter between several monitored AXI-stream links.
// A frame-boundary round-robin arbiter locks the counter to one port from its
// first beat to tlast; frame starts it cannot measure are pulsed and counted.
//  clk, rst              : clock, synchronous active-high reset
//  monitor_axis_tkeep    : per-port tkeep, port i at [i*KEEP_WIDTH +: KEEP_WIDTH]
//  monitor_axis_tvalid   : per-port tvalid
//  monitor_axis_tready   : per-port tready (observed only)
//  monitor_axis_tlast    : per-port tlast
//  frame_len             : length of the last measured frame
//  frame_len_valid       : 1-cycle pulse, frame_len/frame_len_port are new
//  frame_len_port        : port the measured frame came from
//  frame_skip            : 1-cycle pulse, at least one frame start was not measured
//  skip_count            : saturating count of skipped frame starts
//  busy                  : arbiter is locked to a port
module axis_frame_len_arb
  import axis_frame_len_arb_pkg::*;
#(
  parameter int unsigned PORTS          = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter bit          KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned SKIP_CNT_WIDTH = 16,
  parameter int unsigned PORT_WIDTH     = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic [PORTS-1:0]            monitor_axis_tvalid,
  input  logic [PORTS-1:0]            monitor_axis_tready,
  input  logic [PORTS-1:0]            monitor_axis_tlast,
  output logic [LEN_WIDTH-1:0]        frame_len,
  output logic                        frame_len_valid,
  output logic [PORT_WIDTH-1:0]       frame_len_port,
  output logic                        frame_skip,
  output logic [SKIP_CNT_WIDTH-1:0]   skip_count,
  output logic                        busy
);

  localparam logic [SKIP_CNT_WIDTH-1:0] SKIP_MAX = '1;

  arb_state_e            state, state_nxt;
  logic [PORT_WIDTH-1:0] grant, grant_nxt;
  logic [PORT_WIDTH-1:0] rr_ptr, rr_nxt;
  logic [PORTS-1:0]      in_frame;
  logic [PORTS-1:0]      synced;

  logic [PORTS-1:0]      beat_c;
  logic [PORTS-1:0]      elig_c;
  logic [PORTS-1:0]      grant_mask_c;
  logic [PORTS-1:0]      skip_mask_c;
  logic                  pick_found_c;
  logic [PORT_WIDTH-1:0] pick_port_c;
  logic                  sel_active_c;
  logic [PORT_WIDTH-1:0] sel_port_c;
  logic [KEEP_WIDTH-1:0] mux_tkeep_c;
  logic                  mux_tvalid_c;
  logic                  mux_tready_c;
  logic                  mux_tlast_c;
  int unsigned           skip_n_c;
  int unsigned           skip_sum_c;

  // Handshakes and eligible frame starts (first beat on a synced port)
  always_comb begin
    beat_c = monitor_axis_tvalid & monitor_axis_tready;
    elig_c = beat_c & ~in_frame & synced;
  end

  // Frame-position and sync trackers; a port syncs on its first observed tlast
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame <= '0;
      synced   <= '0;
    end else begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        if (beat_c[p]) begin
          in_frame[p] <= ~monitor_axis_tlast[p];
          if (monitor_axis_tlast[p]) begin
            synced[p] <= 1'b1;
          end
        end
      end
    end
  end

  // Round-robin pick: first eligible port at or after rr_ptr
  always_comb begin : rr_pick
    int unsigned           idx;
    logic [PORT_WIDTH-1:0] idx_p;
    pick_found_c = 1'b0;
    pick_port_c  = '0;
    idx          = 0;
    idx_p        = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= PORTS) begin
        idx = idx - PORTS;
      end
      idx_p = PORT_WIDTH'(idx);
      if (!pick_found_c && elig_c[idx_p]) begin
        pick_found_c = 1'b1;
        pick_port_c  = idx_p;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
      busy   <= (state_nxt == ST_LOCKED);
    end
  end

  // FSM next state and counter source selection
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_nxt       = rr_ptr;
    sel_active_c = 1'b0;
    sel_port_c   = '0;
    grant_mask_c = '0;
    case (state)
      ST_IDLE: begin
        if (pick_found_c) begin
          sel_active_c = 1'b1;
          sel_port_c   = pick_port_c;
          grant_mask_c = PORTS'(1) << pick_port_c;
          if (monitor_axis_tlast[pick_port_c]) begin
            rr_nxt = PORT_WIDTH'(rr_next(32'(pick_port_c), PORTS));
          end else begin
            state_nxt = ST_LOCKED;
            grant_nxt = pick_port_c;
          end
        end
      end
      ST_LOCKED: begin
        sel_active_c = 1'b1;
        sel_port_c   = grant;
        if (beat_c[grant] && monitor_axis_tlast[grant]) begin
          state_nxt = ST_IDLE;
          rr_nxt    = PORT_WIDTH'(rr_next(32'(grant), PORTS));
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter feed: selected port, or an idle (tvalid=0) beat when none
  always_comb begin
    mux_tkeep_c  = monitor_axis_tkeep[32'(sel_port_c)*KEEP_WIDTH +: KEEP_WIDTH];
    mux_tvalid_c = sel_active_c & monitor_axis_tvalid[sel_port_c];
    mux_tready_c = monitor_axis_tready[sel_port_c];
    mux_tlast_c  = monitor_axis_tlast[sel_port_c];
  end

  // Skipped starts: every eligible start not granted this cycle
  always_comb begin
    skip_mask_c = elig_c & ~grant_mask_c;
    skip_n_c    = 0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      skip_n_c += 32'(skip_mask_c[p]);
    end
    skip_sum_c = 32'(skip_count) + skip_n_c;
  end

  // Skip pulse, saturating skip counter, measured-port register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_skip     <= 1'b0;
      skip_count     <= '0;
      frame_len_port <= '0;
    end else begin
      frame_skip <= |skip_mask_c;
      if (skip_sum_c > 32'(SKIP_MAX)) begin
        skip_count <= SKIP_MAX;
      end else begin
        skip_count <= SKIP_CNT_WIDTH'(skip_sum_c);
      end
      if (mux_tvalid_c && mux_tready_c && mux_tlast_c) begin
        frame_len_port <= sel_port_c;
      end
    end
  end

  axis_frame_len_arb_len #(
    .KEEP_ENABLE (KEEP_ENABLE),
    .KEEP_WIDTH  (KEEP_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH)
  ) u_len (
    .clk             (clk),
    .rst             (rst),
    .tkeep           (mux_tkeep_c),
    .tvalid          (mux_tvalid_c),
    .tready          (mux_tready_c),
    .tlast           (mux_tlast_c),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid)
  );

endmodule

// File: tb/tb_axis_frame_len_arb.sv
// Self-checking bench for axis_frame_len_arb: directed vector table,
// hand-written reset/saturation sequences, and randomized traffic against
// a behavioural model.
module tb_axis_frame_len_arb;

  localparam int unsigned PORTS = 4;
  localparam int unsigned KW    = 1;
  localparam int unsigned LW    = 16;
  localparam int unsigned SW    = 6;
  localparam int unsigned PW    = 2;
  localparam int          SMAX  = (1 << SW) - 1;

  logic                  clk;
  logic                  rst;
  logic [PORTS*KW-1:0]   tkeep;
  logic [PORTS-1:0]      tvalid;
  logic [PORTS-1:0]      tready;
  logic [PORTS-1:0]      tlast;
  logic [LW-1:0]         frame_len;
  logic                  frame_len_valid;
  logic [PW-1:0]         frame_len_port;
  logic                  frame_skip;
  logic [SW-1:0]         skip_count;
  logic                  busy;

  int n_cmp;
  int n_fail;

  axis_frame_len_arb #(
    .PORTS          (PORTS),
    .DATA_WIDTH     (8),
    .LEN_WIDTH      (LW),
    .SKIP_CNT_WIDTH (SW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .monitor_axis_tkeep  (tkeep),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .frame_len           (frame_len),
    .frame_len_valid     (frame_len_valid),
    .frame_len_port      (frame_len_port),
    .frame_skip          (frame_skip),
    .skip_count          (skip_count),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tv;
    logic [3:0] tl;
    logic       e_valid;
    int         e_len;
    int         e_port;
    logic       e_skip;
    int         e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] tv, input logic [3:0] tl, input logic ev,
                              input int el, input int ep, input logic es, input int ec,
                              input logic eb);
    vec_t v;
    v.tv = tv; v.tl = tl; v.e_valid = ev; v.e_len = el; v.e_port = ep;
    v.e_skip = es; v.e_cnt = ec; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic [3:0] tv, input logic [3:0] tr, input logic [3:0] tl,
                      input logic r);
    tvalid = tv;
    tready = tr;
    tlast  = tl;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input int el, input int ep,
                         input logic es, input int ec, input logic eb);
    chk({tag, " frame_len_valid"}, int'(frame_len_valid), int'(ev));
    chk({tag, " frame_len"},       int'(frame_len),       el);
    chk({tag, " frame_len_port"},  int'(frame_len_port),  ep);
    chk({tag, " frame_skip"},      int'(frame_skip),      int'(es));
    chk({tag, " skip_count"},      int'(skip_count),      ec);
    chk({tag, " busy"},            int'(busy),            int'(eb));
  endtask

  // Behavioural model: owner = port holding the counter, -1 when free
  int  m_owner, m_rr, m_acc, m_len, m_port, m_cnt;
  bit  m_valid, m_skip, m_busy;
  bit  m_in_frame[PORTS];
  bit  m_sync[PORTS];

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_acc = 0; m_len = 0; m_port = 0; m_cnt = 0;
    m_valid = 0; m_skip = 0; m_busy = 0;
    for (int p = 0; p < PORTS; p++) begin
      m_in_frame[p] = 0;
      m_sync[p]     = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] tv, input logic [3:0] tr, input logic [3:0] tl);
    bit b[PORTS];
    bit start[PORTS];
    int granted, active, nskip, q;
    granted = -1;
    nskip   = 0;
    for (int p = 0; p < PORTS; p++) begin
      b[p]     = tv[p] && tr[p];
      start[p] = b[p] && !m_in_frame[p] && m_sync[p];
    end
    if (m_owner < 0) begin
      for (int k = 0; k < PORTS; k++) begin
        q = (m_rr + k) % PORTS;
        if (granted < 0 && start[q]) granted = q;
      end
    end
    active  = (m_owner >= 0) ? m_owner : granted;
    m_valid = 0;
    if (active >= 0 && b[active]) begin
      m_acc++;
      if (tl[active]) begin
        m_len   = m_acc % (1 << LW);
        m_valid = 1;
        m_port  = active;
        m_acc   = 0;
        m_owner = -1;
        m_rr    = (active + 1) % PORTS;
      end else begin
        m_owner = active;
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      if (start[p] && p != granted) nskip++;
    end
    m_skip = (nskip > 0);
    m_cnt  = (m_cnt + nskip > SMAX) ? SMAX : m_cnt + nskip;
    for (int p = 0; p < PORTS; p++) begin
      if (b[p]) begin
        if (tl[p]) begin
          m_in_frame[p] = 0;
          m_sync[p]     = 1;
        end else begin
          m_in_frame[p] = 1;
        end
      end
    end
    m_busy = (m_owner >= 0);
  endtask

  initial begin
    logic [3:0] rv, rr, rl;
    n_cmp  = 0;
    n_fail = 0;
    tkeep  = '1;
    step(4'h0, 4'h0, 4'h0, 1'b1);
    step(4'h0, 4'h0, 4'h0, 1'b1);
    chk_all("reset", 1'b0, 0, 0, 1'b0, 0, 1'b0);

    // Directed table (tready high on all ports)
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 0, 0, 0, 0));  // sync all ports, unmeasured
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 1));  // port0 3-beat frame
    vecs.push_back(mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'h1, 4'h1, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(4'h8, 4'h8, 1, 1, 3, 0, 0, 0));  // single beat port3, rr -> 0
    vecs.push_back(mk(4'h6, 4'h0, 0, 1, 3, 1, 1, 1));  // ports 1,2 start: 1 wins
    vecs.push_back(mk(4'h6, 4'h6, 1, 2, 1, 0, 1, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 2, 1, 0, 1, 1));  // port0 5 beats vs port3
    vecs.push_back(mk(4'h9, 4'h0, 0, 2, 1, 1, 2, 1));
    vecs.push_back(mk(4'h9, 4'h8, 0, 2, 1, 0, 2, 1));
    vecs.push_back(mk(4'h1, 4'h0, 0, 2, 1, 0, 2, 1));
    vecs.push_back(mk(4'h1, 4'h1, 1, 5, 0, 0, 2, 0));
    vecs.push_back(mk(4'h2, 4'h0, 0, 5, 0, 0, 2, 1));  // back-to-back on port1/port2
    vecs.push_back(mk(4'h6, 4'h2, 1, 2, 1, 1, 3, 0));
    vecs.push_back(mk(4'h4, 4'h4, 0, 2, 1, 0, 3, 0));
    vecs.push_back(mk(4'h8, 4'h8, 1, 1, 3, 0, 3, 0));
    vecs.push_back(mk(4'hF, 4'hF, 1, 1, 0, 1, 6, 0));  // round robin 0,1,2,3,0
    vecs.push_back(mk(4'hF, 4'hF, 1, 1, 1, 1, 9, 0));
    vecs.push_back(mk(4'hF, 4'hF, 1, 1, 2, 1, 12, 0));
    vecs.push_back(mk(4'hF, 4'hF, 1, 1, 3, 1, 15, 0));
    vecs.push_back(mk(4'hF, 4'hF, 1, 1, 0, 1, 18, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tv, 4'hF, vecs[i].tl, 1'b0);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_len, vecs[i].e_port,
              vecs[i].e_skip, vecs[i].e_cnt, vecs[i].e_busy);
    end

    // Reset in the middle of a port2 frame
    step(4'h4, 4'hF, 4'h0, 1'b0);
    chk("rst_mid lock busy", int'(busy), 1);
    step(4'h4, 4'hF, 4'h0, 1'b1);
    chk_all("rst_mid reset", 1'b0, 0, 0, 1'b0, 0, 1'b0);
    step(4'h4, 4'hF, 4'h0, 1'b0);
    chk("rst_mid cut busy", int'(busy), 0);
    step(4'h4, 4'hF, 4'h4, 1'b0);
    chk_all("rst_mid cut end", 1'b0, 0, 0, 1'b0, 0, 1'b0);
    step(4'h4, 4'hF, 4'h0, 1'b0);
    chk("rst_mid new busy", int'(busy), 1);
    step(4'h4, 4'hF, 4'h4, 1'b0);
    chk_all("rst_mid new end", 1'b1, 2, 2, 1'b0, 0, 1'b0);

    // Skip counter saturation
    step(4'hB, 4'hF, 4'hB, 1'b0);
    chk("sat sync skip", int'(frame_skip), 0);
    for (int i = 0; i < 21; i++) begin
      step(4'hF, 4'hF, 4'hF, 1'b0);
    end
    chk("sat reach max", int'(skip_count), SMAX);
    step(4'h3, 4'hF, 4'h3, 1'b0);
    chk("sat hold max", int'(skip_count), SMAX);
    chk("sat pulse", int'(frame_skip), 1);
    step(4'h0, 4'hF, 4'h0, 1'b0);
    chk("sat idle pulse", int'(frame_skip), 0);

    // Randomized traffic against the model
    step(4'h0, 4'h0, 4'h0, 1'b1);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < PORTS; p++) begin
        rv[p] = ($urandom_range(1, 0) == 1);
        rr[p] = ($urandom_range(3, 0) != 0);
        rl[p] = ($urandom_range(3, 0) == 0);
      end
      model_step(rv, rr, rl);
      step(rv, rr, rl, 1'b0);
      chk_all($sformatf("rand%0d", c), m_valid, m_len, m_port, m_skip, m_cnt, m_busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
